// File: rtl/spi_shifter_pkg.sv
// rtl/spi_shifter_pkg.sv - shared SPI constants: mode bit positions and shifter state encoding
package spi_shifter_pkg;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  // Number of SCLK edges in one byte transfer.
  localparam logic [4:0] LAST_EDGE = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
  function automatic logic samples_on(input logic cpha, input logic leading);
    return leading ^ cpha;
  endfunction

endpackage

// File: rtl/spi_shifter_if.sv
// rtl/spi_shifter_if.sv - byte request/response bundle between a host and the SPI shifter
interface spi_shifter_if;

  logic       i_start;
  logic [1:0] i_mode;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_start, i_mode, i_data,
    input  o_data, o_busy, o_done
  );

  modport slave (
    input  i_start, i_mode, i_data,
    output o_data, o_busy, o_done
  );

endinterface

// File: rtl/spi_tick.sv
// rtl/spi_tick.sv - half-period tick: pulses every HALF_PERIOD enabled cycles, held at zero when disabled
module spi_tick #(
  parameter int HALF_PERIOD = 24
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  logic [7:0] cnt_q, cnt_d;

  // Counter sits at zero outside a transfer, so the acceptance cycle counts as phase 0.
  always_comb begin
    o_tick = i_en && (cnt_q == 8'(HALF_PERIOD - 1));
    cnt_d  = 8'd0;
    if (i_en && !o_tick) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_shifter.sv
// rtl/spi_shifter.sv - SPI master byte shifter, all four modes, MSB first
module spi_shifter
  import spi_shifter_pkg::*;
#(
  parameter int HALF_PERIOD = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  spi_shifter_if.slave bus,
  output logic        o_SCLK,
  output logic        o_MOSI,
  input  logic        i_MISO
);

  state_e     state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       edge_now_q, edge_now_d;
  logic [4:0] edge_q, edge_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] data_q, data_d;

  logic accept;
  logic last_edge;
  logic tick_en;
  logic tick;
  logic leading_next;

  spi_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (tick_en),
    .o_tick (tick)
  );

  always_comb begin
    accept    = bus.i_start && !busy_q;
    last_edge = (state_q == ST_XFER) && (edge_q == LAST_EDGE);
    tick_en   = accept || ((state_q == ST_XFER) && (edge_q != LAST_EDGE));

    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    edge_d       = edge_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    data_d       = data_q;
    edge_now_d   = tick;
    leading_next = 1'b0;

    // MISO is taken in the cycle SCLK has just moved; edge_q is that edge's number.
    if ((state_q == ST_XFER) && edge_now_q && samples_on(cpha_q, edge_q[0])) begin
      rx_d = {rx_q[6:0], i_MISO};
    end

    if (last_edge) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      data_d  = rx_d;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end

    if (accept) begin
      state_d = ST_XFER;
      busy_d  = 1'b1;
      cpol_d  = bus.i_mode[CPOL_BIT];
      cpha_d  = bus.i_mode[CPHA_BIT];
      sclk_d  = bus.i_mode[CPOL_BIT];
      edge_d  = 5'd0;
      if (bus.i_mode[CPHA_BIT]) begin
        tx_d = bus.i_data;
      end else begin
        mosi_d = bus.i_data[7];
        tx_d   = {bus.i_data[6:0], 1'b0};
      end
    end else if (state_q != ST_XFER) begin
      sclk_d = cpol_q;
    end

    // Edge actions stack on top of acceptance so HALF_PERIOD=1 gets its first edge at cycle 1.
    if (tick) begin
      leading_next = !edge_d[0];
      sclk_d       = !sclk_d;
      if (cpha_d ? leading_next : (!leading_next && (edge_d != 5'd15))) begin
        mosi_d = tx_d[7];
        tx_d   = {tx_d[6:0], 1'b0};
      end
      edge_d = edge_d + 5'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      edge_now_q <= 1'b0;
      edge_q     <= 5'd0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      edge_now_q <= edge_now_d;
      edge_q     <= edge_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
    end
  end

  assign bus.o_data = data_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign o_SCLK     = sclk_q;
  assign o_MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_shifter.sv
// tb/tb_spi_shifter.sv - scoreboard bench for spi_shifter: HALF_PERIOD=2 and HALF_PERIOD=1 instances
module tb_spi_shifter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_shifter_if bus_a ();
  spi_shifter_if bus_b ();

  logic sclk_a, mosi_a, miso_a;
  logic sclk_b, mosi_b;

  int         miso_sel;
  int         lead_cnt;
  int         slave_base;
  int         slave_idx;
  logic [7:0] slave_pat;
  logic       slave_miso;

  assign slave_idx  = lead_cnt - slave_base;
  assign slave_miso = (slave_idx >= 1 && slave_idx <= 8) ? slave_pat[8 - slave_idx] : 1'b0;
  assign miso_a     = (miso_sel == 0) ? mosi_a :
                      (miso_sel == 1) ? 1'b1 :
                      (miso_sel == 2) ? slave_miso : 1'b0;

  // Slave model advances its output on each rising (leading for CPOL=0) SCLK edge.
  always @(posedge sclk_a) lead_cnt++;

  spi_shifter #(.HALF_PERIOD(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a),
    .o_SCLK(sclk_a), .o_MOSI(mosi_a), .i_MISO(miso_a)
  );

  spi_shifter #(.HALF_PERIOD(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b),
    .o_SCLK(sclk_b), .o_MOSI(mosi_b), .i_MISO(mosi_b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected byte whenever a DUT reports completion.
  always @(negedge clk) begin
    if (rst_n && bus_a.o_done) begin
      if (exp_q_a.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        check("a_rx_data", {24'd0, bus_a.o_data}, {24'd0, exp_q_a.pop_front()});
        check("a_busy_in_done", {31'd0, bus_a.o_busy}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_b.o_done) begin
      if (exp_q_b.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        check("b_rx_data", {24'd0, bus_b.o_data}, {24'd0, exp_q_b.pop_front()});
        check("b_busy_in_done", {31'd0, bus_b.o_busy}, 32'd0);
      end
    end
  end

  int         data_glitch = 0;
  logic [7:0] prev_data_a = 8'h00;
  logic       prev_rst = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_rst && (bus_a.o_data != prev_data_a) && !bus_a.o_done) data_glitch++;
    prev_data_a = bus_a.o_data;
    prev_rst    = rst_n;
  end

  int   tr_edges, tr_edge_bad, tr_done_cnt, tr_done_cyc, tr_mosi_bad;
  logic tr_sclk_c1, tr_sclk_done;

  // Start a transfer on dut_a (HALF_PERIOD=2) and trace 40 cycles after acceptance.
  task automatic xfer_a(input logic [1:0] mode, input logic [7:0] data, input int sel,
                        input int glitch_at, input int abort_at);
    logic ps, pm, lvl;
    @(negedge clk);
    miso_sel      = sel;
    slave_base    = lead_cnt;
    bus_a.i_start = 1'b1;
    bus_a.i_mode  = mode;
    bus_a.i_data  = data;
    tr_edges = 0; tr_edge_bad = 0; tr_done_cnt = 0; tr_done_cyc = -1; tr_mosi_bad = 0;
    tr_sclk_c1 = 1'bx; tr_sclk_done = 1'bx;
    lvl = mode[0] ? ~mode[1] : mode[1];
    ps = 1'b0; pm = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tr_sclk_c1    = sclk_a;
        bus_a.i_start = 1'b0;
      end else begin
        if (sclk_a != ps) begin
          tr_edges++;
          if (c != 2 * tr_edges) tr_edge_bad++;
        end
        if ((mosi_a != pm) && !((sclk_a != ps) && (sclk_a == lvl))) tr_mosi_bad++;
      end
      if (bus_a.o_done) begin
        tr_done_cnt++;
        tr_done_cyc  = c;
        tr_sclk_done = sclk_a;
      end
      ps = sclk_a;
      pm = mosi_a;
      if (c == glitch_at) begin
        bus_a.i_start = 1'b1;
        bus_a.i_data  = 8'h00;
        bus_a.i_mode  = ~mode;
      end else if (glitch_at > 0 && c == glitch_at + 1) begin
        bus_a.i_start = 1'b0;
        bus_a.i_data  = data;
        bus_a.i_mode  = mode;
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              {20'd0, bus_a.o_data, bus_a.o_busy, bus_a.o_done, sclk_a, mosi_a}, 32'd0);
      end else if (abort_at > 0 && c == abort_at + 2) begin
        rst_n = 1'b1;
      end
    end
  endtask

  int d1, d2, nd, busy_bad;

  initial begin
    rst_n = 1'b1;
    miso_sel = 0; slave_base = 0; lead_cnt = 0; slave_pat = 8'h5A;
    bus_a.i_start = 1'b0; bus_a.i_mode = 2'b00; bus_a.i_data = 8'h00;
    bus_b.i_start = 1'b0; bus_b.i_mode = 2'b00; bus_b.i_data = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    check("reset_a", {20'd0, bus_a.o_data, bus_a.o_busy, bus_a.o_done, sclk_a, mosi_a}, 32'd0);
    check("reset_b", {20'd0, bus_b.o_data, bus_b.o_busy, bus_b.o_done, sclk_b, mosi_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0, loopback.
    exp_q_a.push_back(8'hA5);
    xfer_a(2'b00, 8'hA5, 0, 0, 0);
    check("m0_edge_count", tr_edges, 16);
    check("m0_edge_cycles", tr_edge_bad, 0);
    check("m0_done_cycle", tr_done_cyc, 33);
    check("m0_done_count", tr_done_cnt, 1);
    check("m0_mosi_edges", tr_mosi_bad, 0);

    // Mode 3, MISO high.
    exp_q_a.push_back(8'hFF);
    xfer_a(2'b11, 8'h3C, 1, 0, 0);
    check("m3_sclk_cycle1", {31'd0, tr_sclk_c1}, 32'd1);
    check("m3_edge_cycles", tr_edge_bad, 0);
    check("m3_edge_count", tr_edges, 16);
    check("m3_sclk_in_done", {31'd0, tr_sclk_done}, 32'd1);
    check("m3_mosi_falling", tr_mosi_bad, 0);
    check("m3_sclk_idle", {31'd0, sclk_a}, 32'd1);

    // Mode 1, slave model shifting 5A.
    exp_q_a.push_back(8'h5A);
    xfer_a(2'b01, 8'hC3, 2, 0, 0);
    check("m1_done_cycle", tr_done_cyc, 33);
    check("m1_mosi_edges", tr_mosi_bad, 0);

    // Start request during busy must be ignored.
    exp_q_a.push_back(8'hA5);
    xfer_a(2'b00, 8'hA5, 0, 10, 0);
    check("ign_done_count", tr_done_cnt, 1);
    check("ign_sclk_idle", {31'd0, sclk_a}, 32'd0);

    // Reset at cycle 15, then a fresh transfer.
    xfer_a(2'b00, 8'hC3, 0, 0, 15);
    check("abort_done_count", tr_done_cnt, 0);
    exp_q_a.push_back(8'h96);
    xfer_a(2'b10, 8'h96, 0, 0, 0);
    check("post_reset_done_cycle", tr_done_cyc, 33);
    check("post_reset_edges", tr_edges, 16);
    check("m2_mosi_edges", tr_mosi_bad, 0);

    // Back-to-back on HALF_PERIOD=1 with start held high.
    exp_q_b.push_back(8'h81);
    exp_q_b.push_back(8'h7E);
    @(negedge clk);
    bus_b.i_start = 1'b1;
    bus_b.i_mode  = 2'b00;
    bus_b.i_data  = 8'h81;
    d1 = -1; d2 = -1; nd = 0; busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus_b.o_done) begin
        nd++;
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      if (d2 < 0 && !bus_b.o_busy && !bus_b.o_done) busy_bad++;
      if (c == 1) bus_b.i_data = 8'h7E;
      if (d1 > 0 && c == d1 + 1) bus_b.i_start = 1'b0;
    end
    check("b2b_done_count", nd, 2);
    check("b2b_first_done", d1, 17);
    check("b2b_spacing", d2 - d1, 17);
    check("b2b_busy_gaps", busy_bad, 0);

    repeat (3) @(negedge clk);
    check("a_pending", exp_q_a.size(), 0);
    check("b_pending", exp_q_b.size(), 0);
    check("a_data_stable", data_glitch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_shifter.md
SPI_SHIFTER -- requirements
Module: spi_shifter

Interface
REQ-001 The module SHALL have parameter HALF_PERIOD, default 24, giving the number of i_clk cycles per SCLK half-period (48 MHz / 48 = 1 MHz SCLK); legal range 1..255.
REQ-002 The module SHALL have port i_clk  input  1  system clock.
REQ-003 The module SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port i_start  input  1  request one byte transfer.
REQ-005 The module SHALL have port i_mode  input  2  SPI mode: bit1 = CPOL, bit0 = CPHA.
REQ-006 The module SHALL have port i_data  input  8  byte to transmit, MSB first.
REQ-007 The module SHALL have port o_data  output  8  last byte received, MSB first.
REQ-008 The module SHALL have port o_busy  output  1  transfer in progress.
REQ-009 The module SHALL have port o_done  output  1  one-cycle pulse when a transfer completes.
REQ-010 The module SHALL have port o_SCLK  output  1  SPI clock.
REQ-011 The module SHALL have port o_MOSI  output  1  master out, slave in.
REQ-012 The module SHALL have port i_MISO  input  1  master in, slave out; sampled directly, with no synchronizer.

Function
REQ-013 The module SHALL implement the states IDLE, XFER and DONE.
REQ-014 The module SHALL accept i_start only when o_busy=0; it SHALL then latch i_data and i_mode and enter XFER.
- The acceptance cycle is cycle 0.
- o_busy SHALL be 1 from cycle 1.
REQ-015 In XFER, o_SCLK SHALL toggle at cycles k*HALF_PERIOD, for k=1..16; odd k is the leading edge and even k is the trailing edge.
REQ-016 With CPHA=0:
- o_MOSI SHALL present bit7 from cycle 1.
- i_MISO SHALL be sampled on each leading edge.
- o_MOSI SHALL advance to the next bit on each trailing edge except the 16th.
REQ-017 With CPHA=1:
- o_MOSI SHALL present the next bit on each leading edge, starting with bit7.
- i_MISO SHALL be sampled on each trailing edge.
REQ-018 Sampling SHALL capture i_MISO as registered by i_clk in the edge cycle; received bits SHALL shift in MSB first.
REQ-019 At cycle 16*HALF_PERIOD+1 the state SHALL be DONE:
- o_done=1 for exactly one cycle.
- o_busy=0.
- o_data updated with the received byte.
- Next state IDLE.
REQ-020 o_data SHALL change only in the DONE cycle and at reset.
REQ-021 i_start asserted in the DONE cycle SHALL be accepted, giving a back-to-back transfer; that DONE cycle is the new cycle 0.
REQ-022 i_start, i_mode and i_data changes while o_busy=1 SHALL be ignored, with no effect on the current or any later transfer.
REQ-023 In IDLE and DONE, o_SCLK SHALL equal the CPOL latched at the most recent acceptance, and o_MOSI SHALL hold its last value.
REQ-024 Latching a CPOL that differs from the idle level SHALL NOT produce an SCLK edge before cycle HALF_PERIOD; o_SCLK SHALL take the new CPOL level at cycle 1.
REQ-025 With HALF_PERIOD=1, edges SHALL occur on every cycle 1..16 and o_done on cycle 17.

Reset
REQ-026 While i_rst_n=0, regardless of clock and mid-transfer, the module SHALL immediately force:
- state IDLE
- o_busy=0, o_done=0
- o_data=8'h00
- o_SCLK=0, o_MOSI=0
- latched CPOL=0
- bit and half-period counters 0
REQ-027 After i_rst_n rises, the first i_start SHALL be accepted on the next rising i_clk edge; an interrupted transfer SHALL NOT resume and SHALL NOT pulse o_done.

Structure
REQ-028 Mode bit positions (CPOL=1, CPHA=0) and state encodings SHALL live in the shared SPI constants package, which the register-file block also uses.
REQ-029 The half-period tick generator SHALL be one sub-module, spi_tick: an enable-gated counter producing a pulse every HALF_PERIOD cycles and cleared on acceptance.

Verification
REQ-030 Mode 0, HALF_PERIOD=2, i_data=8'hA5, i_MISO looped to o_MOSI: 16 SCLK edges at cycles 2,4..32; o_done at cycle 33; o_data=8'hA5.
REQ-031 Mode 3, i_data=8'h3C, i_MISO tied 1: SCLK idles high before and after; MOSI changes on falling edges; o_data=8'hFF.
REQ-032 Mode 1, i_MISO driven by a model shifting 8'h5A on leading edges: o_data=8'h5A.
REQ-033 Second i_start with i_data=8'h00 at cycle 10 of an 8'hA5 transfer: ignored; o_data=8'hA5; exactly one o_done pulse.
REQ-034 i_rst_n pulsed low at cycle 15 of a transfer: all outputs at reset values within the reset interval; no o_done; a new start then completes normally.
REQ-035 Back-to-back: i_start held high, HALF_PERIOD=1, i_data=8'h81 then 8'h7E: two o_done pulses 17 cycles apart; o_busy low only in each DONE cycle.
